// File: rtl/mem_arb_ctrl_pkg.sv
// Shared definitions for the memory bus arbiter: stall bit positions, stall
// vectors and the arbiter FSM state encoding.
package mem_arb_ctrl_pkg;

    localparam int STALL_BIT_PC    = 0;
    localparam int STALL_BIT_IF_ID = 1;
    localparam int STALL_BIT_ID_EX = 2;
    localparam int STALL_BIT_EX_MEM = 3;
    localparam int STALL_BIT_MEM_WB = 4;
    localparam int STALL_BIT_WB    = 5;

    typedef logic [STALL_BIT_WB:0] stall_t;

    // Each stall source freezes its own stage and every stage upstream of it.
    localparam stall_t STALL_NONE = '0;
    localparam stall_t STALL_IF   = stall_t'((1 << STALL_BIT_PC) | (1 << STALL_BIT_IF_ID));
    localparam stall_t STALL_ID   = STALL_IF  | stall_t'(1 << STALL_BIT_ID_EX);
    localparam stall_t STALL_EX   = STALL_ID  | stall_t'(1 << STALL_BIT_EX_MEM);
    localparam stall_t STALL_MEM  = STALL_EX  | stall_t'(1 << STALL_BIT_MEM_WB);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GNT_IF = 2'd1,
        ST_GNT_DM = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_ctrl_if.sv
// Pipeline-side request/ack signals, stall inputs/outputs and the external bus
// of the memory arbiter; master = arbiter view, slave = surrounding logic.
interface mem_arb_ctrl_if;
    import mem_arb_ctrl_pkg::*;

    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;

    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_sel;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;

    logic        stallreq_id;
    logic        stallreq_ex;
    stall_t      stall;

    logic        bus_cyc;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_sel, dm_addr, dm_wdata,
               stallreq_id, stallreq_ex, bus_rdata, bus_ack,
        output if_rdata, if_ack, dm_rdata, dm_ack, stall,
               bus_cyc, bus_we, bus_sel, bus_addr, bus_wdata, bus_err
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_sel, dm_addr, dm_wdata,
               stallreq_id, stallreq_ex, bus_rdata, bus_ack,
        input  if_rdata, if_ack, dm_rdata, dm_ack, stall,
               bus_cyc, bus_we, bus_sel, bus_addr, bus_wdata, bus_err
    );

endinterface

// File: rtl/mem_arb_ctrl_stall_ctrl.sv
// Priority merge of the four pipeline stall sources into the per-stage
// stall vector; the most downstream source wins.
module stall_ctrl
    import mem_arb_ctrl_pkg::*;
(
    input  logic   dm_pending,
    input  logic   stallreq_ex,
    input  logic   stallreq_id,
    input  logic   if_pending,
    output stall_t stall
);

    always_comb begin
        if (dm_pending)       stall = STALL_MEM;
        else if (stallreq_ex) stall = STALL_EX;
        else if (stallreq_id) stall = STALL_ID;
        else if (if_pending)  stall = STALL_IF;
        else                  stall = STALL_NONE;
    end

endmodule

// File: rtl/mem_arb_ctrl.sv
// Single-master bus arbiter between instruction fetch and MEM-stage data
// accesses, plus the pipeline stall merge. `MEM_ARB_TIMEOUT_EN adds a bus watchdog.
module mem_arb_ctrl
    import mem_arb_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic           clk,
    input  logic           rst,
    mem_arb_ctrl_if.master arb
);

    arb_state_t state, state_nxt;
    logic       prio_if;
    logic       load_if, load_dm, fin_if, fin_dm, done, abort;
    logic       timeout_hit;
    logic       if_pending, dm_pending;

    // A request whose ack is showing this cycle is already served; masking it
    // keeps the IDLE cycle after completion from re-granting the same access.
    assign if_pending = rst && arb.if_req && !arb.if_ack;
    assign dm_pending = rst && arb.dm_req && !arb.dm_ack;
    assign arb.bus_cyc = (state != ST_IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wait_cnt;

    // Abort on the edge where the count would reach the limit; an ack there wins.
    assign timeout_hit = arb.bus_cyc && !arb.bus_ack && (wait_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst)                      wait_cnt <= '0;
        else if (load_if || load_dm)   wait_cnt <= '0;
        else if (arb.bus_cyc && !arb.bus_ack) wait_cnt <= wait_cnt + CW'(1);
    end
`else
    // Watchdog disabled: a bus cycle waits for its ack indefinitely.
    assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // NOTE: defaulting every combinational output first keeps each path
    // assigned, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (dm_pending && !(if_pending && prio_if)) state_nxt = ST_GNT_DM;
                else if (if_pending)                        state_nxt = ST_GNT_IF;
            end
            ST_GNT_IF, ST_GNT_DM: begin
                if (arb.bus_ack || timeout_hit) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        load_if = (state == ST_IDLE) && (state_nxt == ST_GNT_IF);
        load_dm = (state == ST_IDLE) && (state_nxt == ST_GNT_DM);
        done    = arb.bus_cyc && (arb.bus_ack || timeout_hit);
        fin_if  = done && (state == ST_GNT_IF);
        fin_dm  = done && (state == ST_GNT_DM);
        abort   = timeout_hit;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prio_if       <= 1'b0;
            arb.if_ack    <= 1'b0;
            arb.dm_ack    <= 1'b0;
            arb.bus_err   <= 1'b0;
            arb.bus_we    <= 1'b0;
            arb.bus_sel   <= '0;
            arb.bus_addr  <= '0;
            arb.bus_wdata <= '0;
            arb.if_rdata  <= '0;
            arb.dm_rdata  <= '0;
        end else begin
            prio_if     <= fin_dm;
            arb.if_ack  <= fin_if;
            arb.dm_ack  <= fin_dm;
            arb.bus_err <= abort;
            if (load_if) begin
                arb.bus_we    <= 1'b0;
                arb.bus_sel   <= 4'hF;
                arb.bus_addr  <= arb.if_addr;
                arb.bus_wdata <= '0;
            end else if (load_dm) begin
                arb.bus_we    <= arb.dm_we;
                arb.bus_sel   <= arb.dm_sel;
                arb.bus_addr  <= arb.dm_addr;
                arb.bus_wdata <= arb.dm_wdata;
            end
            if (fin_if) arb.if_rdata <= abort ? '0 : arb.bus_rdata;
            if (fin_dm) begin
                if (abort)            arb.dm_rdata <= '0;
                else if (!arb.bus_we) arb.dm_rdata <= arb.bus_rdata;
            end
        end
    end

    stall_ctrl u_stall_ctrl (
        .dm_pending  (dm_pending),
        .stallreq_ex (rst && arb.stallreq_ex),
        .stallreq_id (rst && arb.stallreq_id),
        .if_pending  (if_pending),
        .stall       (arb.stall)
    );

endmodule

// File: doc/mem_arb_ctrl.md
# mem_arb_ctrl

Shares the single external memory bus between instruction fetch (PC/IF_ID) and the MEM stage's data accesses. Produces the per-stage stall vector that freezes the five-stage pipeline while a fetch or data access waits, and merges the ID load-use and EX multi-cycle stall requests into the same vector. It sits between the pipeline registers and the bus slave, and is the only bus master in the CPU.

## Interface
Parameters:
- TIMEOUT_CYC, 255 — bus wait-cycle limit; used only with the timeout feature.

Ports:
- clk  in  1  — single clock; all state changes on rising edge.
- rst  in  1  — synchronous, active-low reset; rst=0 at a rising edge resets all state.
- if_req  in  1  — fetch request, held until if_ack.
- if_addr  in  32  — fetch address.
- if_rdata  out  32  — fetched word, registered.
- if_ack  out  1  — one-cycle fetch completion pulse.
- dm_req  in  1  — data request, held until dm_ack.
- dm_we  in  1  — 1 = write.
- dm_sel  in  4  — byte enables.
- dm_addr  in  32  — data address.
- dm_wdata  in  32  — write data.
- dm_rdata  out  32  — read data, registered.
- dm_ack  out  1  — one-cycle data completion pulse.
- stallreq_id  in  1  — load-use hazard stall from ID.
- stallreq_ex  in  1  — multi-cycle op stall from EX.
- bus_cyc  out  1  — bus cycle active.
- bus_we, bus_sel, bus_addr, bus_wdata  out  1/4/32/32  — registered bus command.
- bus_rdata  in  32  — slave read data.
- bus_ack  in  1  — slave completion, valid only while bus_cyc=1.
- bus_err  out  1  — one-cycle timeout pulse; constant 0 without the timeout feature.
- stall  out  6  — bit0 PC, bit1 IF_ID, bit2 ID_EX, bit3 EX_MEM, bit4 MEM_WB, bit5 WB.

## Operation
- FSM states: IDLE, GNT_IF, GNT_DM.
- IDLE arbitration:
  - dm_req only → GNT_DM; if_req only → GNT_IF.
  - Both pending: data wins, except immediately after a GNT_DM completion, when IF wins. This prevents fetch starvation.
  - Neither pending: stay in IDLE.
- On entering a grant, the bus_* command registers load from the winner's inputs (IF: bus_we=0, bus_sel=4'hF, bus_wdata=0) and bus_cyc rises.
  - The command is held constant until completion.
- Completion on bus_ack=1: capture bus_rdata into the winner's rdata register, pulse the winner's ack, drop bus_cyc, return to IDLE. Writes leave dm_rdata unchanged.
- A requester that drops its req mid-grant does not abort the bus cycle; the cycle completes and the ack is still pulsed.
- The stall vector is combinational, highest-priority source wins:
  - dm_req && !dm_ack → 6'b011111.
  - else stallreq_ex → 6'b001111.
  - else stallreq_id → 6'b000111.
  - else if_req && !if_ack → 6'b000011.
  - else 6'b000000.
- Reset values: state IDLE; bus_cyc, bus_we, if_ack, dm_ack, bus_err = 0; bus_sel = 0; bus_addr, bus_wdata, if_rdata, dm_rdata = 0. stall = 0 while rst=0.
- Reset mid-transaction: bus_cyc drops at that edge with no ack to either requester. The slave must tolerate an abandoned cycle.

## Timing
- Zero-wait slave: req seen in cycle 0, bus_cyc=1 in cycle 1, bus_ack in cycle 1, ack and rdata valid in cycle 2, new arbitration in cycle 2.
- Minimum request-to-ack latency is 2 cycles. Each wait state adds 1.
- One bus-idle cycle separates back-to-back transactions.
- if_ack and dm_ack never assert in the same cycle.
- bus_ack seen while bus_cyc=0 is ignored.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A wait counter clears on grant and increments each cycle with bus_cyc=1 && !bus_ack.
  - When it reaches TIMEOUT_CYC, the transaction aborts: bus_cyc drops, the winner's ack pulses with rdata=0, bus_err pulses for 1 cycle, FSM returns to IDLE.
  - bus_ack in the same cycle as the limit takes precedence: normal completion, no error.
- Undefined: no counter, waits indefinitely, bus_err tied 0.

## Structure
- Shared package holds:
  - stall constants STALL_NONE, STALL_IF, STALL_ID, STALL_EX, STALL_MEM;
  - stall bit indices;
  - FSM state encoding.
- Sub-module stall_ctrl: the combinational stall priority merge. Inputs: dm_pending, stallreq_ex, stallreq_id, if_pending. Output: stall.

## Test plan
- Fetch only: if_req=1, if_addr=0x100, slave acks cycle 1 with 0x3C010001 → if_ack and if_rdata=0x3C010001 in cycle 2; stall=6'b000011 in cycles 0–1.
- Simultaneous requests from IDLE, dm_addr=0x2000 read, both held → data granted first (dm_ack, stall=6'b011111 until then), then fetch granted; bus_addr sequence 0x2000 then if_addr.
- Write: dm_we=1, dm_sel=4'b0011, dm_wdata=0xDEADBEEF, slave 3 wait states → bus command stable 4 cycles; dm_ack cycle 5; dm_rdata unchanged.
- Stall merge: stallreq_id=1 with stallreq_ex=1 → stall=6'b001111; stallreq_id only → 6'b000111.
- Reset mid-grant: rst=0 during GNT_DM wait state → next cycle bus_cyc=0, all outputs at reset values, no ack.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYC=4, slave never acks → bus_err and dm_ack pulse together, dm_rdata=0, FSM in IDLE afterwards.
